// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter
//
// Shares one 64-bit shift datapath between two requesters. Each cycle a
// round-robin arbiter picks at most one valid requester, the selected
// operation (SLL/SRL/SRA or their 32-bit W variants) is computed
// combinationally, and the result is captured in a single output register
// together with the winning requester's ID. A full output register that
// is being popped can be refilled on the same edge, so one operation per
// cycle is sustained when the consumer never stalls.
//
// Ports:
//   clk                      rising-edge clock
//   reset                    asynchronous active-high reset
//   req_valid[1:0]           per-requester request valid
//   req_ready[1:0]           per-requester accept (at most one bit high)
//   req0_op / req1_op        00 SLL, 01 SRL, 10 SRA, 11 reserved
//   req0_word / req1_word    1 selects the 32-bit W-variant
//   req0_data / req1_data    operand
//   req0_shamt / req1_shamt  shift amount
//   resp_valid               output register holds a result
//   resp_ready               consumer accepts the result
//   resp_data                shift result
//   resp_id                  requester that issued the result
//   resp_err                 result came from the reserved opcode
//   conflict_cnt             saturating count of contended accept cycles

module shift_unit_arbiter #(
  parameter int XLEN     = 64,
  parameter int RR_RESET = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req0_op,
  input  logic             req0_word,
  input  logic [XLEN-1:0]  req0_data,
  input  logic [5:0]       req0_shamt,
  input  logic [1:0]       req1_op,
  input  logic             req1_word,
  input  logic [XLEN-1:0]  req1_data,
  input  logic [5:0]       req1_shamt,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic             resp_id,
  output logic             resp_err,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic {
    RESP_EMPTY = 1'b0,
    RESP_FULL  = 1'b1
  } respState_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  respState_t      r_state;
  respState_t      w_nextState;
  logic            r_ptr;
  logic [XLEN-1:0] r_respData;
  logic            r_respId;
  logic            r_respErr;
  logic [CNT_W-1:0] r_conflictCnt;

  logic            w_canAccept;
  logic [1:0]      w_grant;
  logic            w_grantId;
  logic            w_accept;
  logic            w_pop;
  logic [1:0]      w_op;
  logic            w_word;
  logic [XLEN-1:0] w_data;
  logic [5:0]      w_shamt;
  logic [XLEN-1:0] w_result;
  logic [31:0]     w_res32;
  logic            w_err;

  assign resp_valid   = (r_state == RESP_FULL);
  assign resp_data    = r_respData;
  assign resp_id      = r_respId;
  assign resp_err     = r_respErr;
  assign conflict_cnt = r_conflictCnt;

  assign w_canAccept = !resp_valid || resp_ready;
  assign w_pop       = resp_valid && resp_ready;

  // Round-robin grant: a lone requester always wins; under contention
  // the pointer decides. The ID of the winner also steers the operand mux.
  always_comb begin
    w_grant   = 2'b00;
    w_grantId = 1'b0;
    case (req_valid)
      2'b01: begin
        w_grant   = 2'b01;
        w_grantId = 1'b0;
      end
      2'b10: begin
        w_grant   = 2'b10;
        w_grantId = 1'b1;
      end
      2'b11: begin
        w_grant   = r_ptr ? 2'b10 : 2'b01;
        w_grantId = r_ptr;
      end
      default: begin
        w_grant   = 2'b00;
        w_grantId = 1'b0;
      end
    endcase
  end

  assign req_ready = w_canAccept ? w_grant : 2'b00;
  assign w_accept  = |(req_valid & req_ready);

  assign w_op    = w_grantId ? req1_op    : req0_op;
  assign w_word  = w_grantId ? req1_word  : req0_word;
  assign w_data  = w_grantId ? req1_data  : req0_data;
  assign w_shamt = w_grantId ? req1_shamt : req0_shamt;

  // Shared shifter. W-variants work on the low word with a 5-bit amount and
  // always sign-extend the 32-bit result, including SLLW and SRLW. The
  // reserved opcode passes the operand through and flags an error.
  always_comb begin
    w_res32  = 32'd0;
    w_result = '0;
    w_err    = (w_op == 2'b11);
    if (w_word) begin
      case (w_op)
        2'b00:   w_res32 = w_data[31:0] << w_shamt[4:0];
        2'b01:   w_res32 = w_data[31:0] >> w_shamt[4:0];
        2'b10:   w_res32 = $signed(w_data[31:0]) >>> w_shamt[4:0];
        default: w_res32 = w_data[31:0];
      endcase
      w_result = {{(XLEN-32){w_res32[31]}}, w_res32};
    end else begin
      case (w_op)
        2'b00:   w_result = w_data << w_shamt;
        2'b01:   w_result = w_data >> w_shamt;
        2'b10:   w_result = $signed(w_data) >>> w_shamt;
        default: w_result = w_data;
      endcase
    end
  end

  // Output register occupancy: a new acceptance always leaves it full,
  // even when the old result is popped on the same edge.
  always_comb begin
    w_nextState = r_state;
    if (w_accept) begin
      w_nextState = RESP_FULL;
    end else if (w_pop) begin
      w_nextState = RESP_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RESP_EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Result capture and pointer update happen only on an accepted request;
  // the pointer then favours the requester that just lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_respData <= '0;
      r_respId   <= 1'b0;
      r_respErr  <= 1'b0;
      r_ptr      <= (RR_RESET != 0);
    end else if (w_accept) begin
      r_respData <= w_result;
      r_respId   <= w_grantId;
      r_respErr  <= w_err;
      r_ptr      <= ~w_grantId;
    end
  end

  // Contention counter, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conflictCnt <= '0;
    end else if ((req_valid == 2'b11) && w_canAccept && !(&r_conflictCnt)) begin
      r_conflictCnt <= r_conflictCnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Testbench for shift_unit_arbiter: directed scenarios with hand-computed
// expected values. Inputs change 1 ns after a rising edge; outputs are
// sampled at that point too, well away from the next edge.

module tb_shift_unit_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req0_op;
  logic        req0_word;
  logic [63:0] req0_data;
  logic [5:0]  req0_shamt;
  logic [1:0]  req1_op;
  logic        req1_word;
  logic [63:0] req1_data;
  logic [5:0]  req1_shamt;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        resp_id;
  logic        resp_err;
  logic [15:0] conflict_cnt;

  int passCount;
  int checkCount;

  shift_unit_arbiter #(.XLEN(64), .RR_RESET(0), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req0_op      (req0_op),
    .req0_word    (req0_word),
    .req0_data    (req0_data),
    .req0_shamt   (req0_shamt),
    .req1_op      (req1_op),
    .req1_word    (req1_word),
    .req1_data    (req1_data),
    .req1_shamt   (req1_shamt),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_id      (resp_id),
    .resp_err     (resp_err),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq0(input logic [1:0] op, input logic word,
                         input logic [63:0] data, input logic [5:0] shamt);
    req0_op    = op;
    req0_word  = word;
    req0_data  = data;
    req0_shamt = shamt;
  endtask

  task automatic setReq1(input logic [1:0] op, input logic word,
                         input logic [63:0] data, input logic [5:0] shamt);
    req1_op    = op;
    req1_word  = word;
    req1_data  = data;
    req1_shamt = shamt;
  endtask

  task automatic test_reset();
    // Fill the output register under contention, stall it, then reset mid-cycle.
    resp_ready = 1'b0;
    setReq0(2'b00, 1'b0, 64'd5, 6'd1);
    setReq1(2'b01, 1'b0, 64'd8, 6'd1);
    req_valid = 2'b11;
    tick();
    req_valid = 2'b00;
    #1;
    checkCount++;
    if (resp_valid !== 1'b1 || resp_data !== 64'd10 || conflict_cnt !== 16'd1)
      $display("[TB] FAIL reset_prefill: valid=%0b data=%h cnt=%0d, required valid=1 data=%h cnt=1",
               resp_valid, resp_data, conflict_cnt, 64'd10);
    else passCount++;

    reset = 1'b1;
    #1;
    checkCount++;
    if (resp_valid !== 1'b0 || resp_data !== 64'd0 || resp_id !== 1'b0 ||
        resp_err !== 1'b0 || conflict_cnt !== 16'd0)
      $display("[TB] FAIL reset_async: valid=%0b data=%h id=%0b err=%0b cnt=%0d, required all zero",
               resp_valid, resp_data, resp_id, resp_err, conflict_cnt);
    else passCount++;

    tick();
    reset = 1'b0;
    tick();
    tick();
    checkCount++;
    if (resp_valid !== 1'b0)
      $display("[TB] FAIL reset_idle: resp_valid=%0b, required 0", resp_valid);
    else passCount++;

    // Pointer must favour requester 0 after reset.
    req_valid = 2'b11;
    #1;
    checkCount++;
    if (req_ready !== 2'b01)
      $display("[TB] FAIL reset_pointer: req_ready=%b, required 01", req_ready);
    else passCount++;
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_sra_srl();
    resp_ready = 1'b1;
    setReq0(2'b10, 1'b0, 64'h8000_0000_0000_0000, 6'd63);
    req_valid = 2'b01;
    tick();
    checkCount++;
    if (resp_valid !== 1'b1 || resp_data !== 64'hFFFF_FFFF_FFFF_FFFF ||
        resp_id !== 1'b0 || resp_err !== 1'b0)
      $display("[TB] FAIL sra63: valid=%0b data=%h id=%0b err=%0b, required 1 %h 0 0",
               resp_valid, resp_data, resp_id, resp_err, 64'hFFFF_FFFF_FFFF_FFFF);
    else passCount++;

    setReq0(2'b01, 1'b0, 64'h8000_0000_0000_0000, 6'd63);
    tick();
    checkCount++;
    if (resp_valid !== 1'b1 || resp_data !== 64'h0000_0000_0000_0001 || resp_id !== 1'b0)
      $display("[TB] FAIL srl63: valid=%0b data=%h id=%0b, required 1 %h 0",
               resp_valid, resp_data, resp_id, 64'h1);
    else passCount++;

    req_valid = 2'b00;
    tick();
    checkCount++;
    if (resp_valid !== 1'b0)
      $display("[TB] FAIL pop_empty: resp_valid=%0b, required 0", resp_valid);
    else passCount++;
  endtask

  task automatic test_word_ops();
    resp_ready = 1'b1;
    setReq1(2'b01, 1'b1, 64'h0000_0000_8000_0000, 6'h24);
    req_valid = 2'b10;
    tick();
    checkCount++;
    if (resp_data !== 64'h0000_0000_0800_0000 || resp_id !== 1'b1 || resp_err !== 1'b0)
      $display("[TB] FAIL srlw: data=%h id=%0b err=%0b, required %h 1 0",
               resp_data, resp_id, resp_err, 64'h0000_0000_0800_0000);
    else passCount++;

    setReq1(2'b10, 1'b1, 64'h0000_0000_8000_0000, 6'd4);
    tick();
    checkCount++;
    if (resp_data !== 64'hFFFF_FFFF_F800_0000 || resp_id !== 1'b1)
      $display("[TB] FAIL sraw: data=%h id=%0b, required %h 1",
               resp_data, resp_id, 64'hFFFF_FFFF_F800_0000);
    else passCount++;

    setReq1(2'b00, 1'b1, 64'h0000_0000_0000_0001, 6'd31);
    tick();
    checkCount++;
    if (resp_data !== 64'hFFFF_FFFF_8000_0000 || resp_id !== 1'b1)
      $display("[TB] FAIL sllw: data=%h id=%0b, required %h 1",
               resp_data, resp_id, 64'hFFFF_FFFF_8000_0000);
    else passCount++;

    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0]  expId;
    logic [63:0] expData;
    expId = 4'b1010;
    resp_ready = 1'b1;
    // Requester 0: 1 << 1 = 2; requester 1: 8 >> 1 = 4.
    setReq0(2'b00, 1'b0, 64'd1, 6'd1);
    setReq1(2'b01, 1'b0, 64'd8, 6'd1);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      expData = expId[i] ? 64'd4 : 64'd2;
      checkCount++;
      if (resp_valid !== 1'b1 || resp_id !== expId[i] || resp_data !== expData)
        $display("[TB] FAIL rr_cycle%0d: valid=%0b id=%0b data=%h, required 1 %0b %h",
                 i, resp_valid, resp_id, resp_data, expId[i], expData);
      else passCount++;
    end
    req_valid = 2'b00;
    #1;
    checkCount++;
    if (conflict_cnt !== 16'd4)
      $display("[TB] FAIL rr_conflicts: conflict_cnt=%0d, required 4", conflict_cnt);
    else passCount++;
    tick();
  endtask

  task automatic test_back_to_back();
    // Pointer is at 0 after the alternating sequence ended on requester 1.
    resp_ready = 1'b1;
    req_valid  = 2'b11;
    tick();
    resp_ready = 1'b0;
    #1;
    checkCount++;
    if (resp_id !== 1'b0 || resp_data !== 64'd2 || conflict_cnt !== 16'd5)
      $display("[TB] FAIL bp_fill: id=%0b data=%h cnt=%0d, required 0 %h 5",
               resp_id, resp_data, conflict_cnt, 64'd2);
    else passCount++;

    for (int i = 0; i < 3; i++) begin
      checkCount++;
      if (req_ready !== 2'b00 || resp_valid !== 1'b1 || resp_data !== 64'd2 ||
          resp_id !== 1'b0 || conflict_cnt !== 16'd5)
        $display("[TB] FAIL bp_hold%0d: ready=%b valid=%0b data=%h id=%0b cnt=%0d, required 00 1 %h 0 5",
                 i, req_ready, resp_valid, resp_data, resp_id, conflict_cnt, 64'd2);
      else passCount++;
      tick();
    end

    resp_ready = 1'b1;
    #1;
    checkCount++;
    if (req_ready !== 2'b10)
      $display("[TB] FAIL bp_release_ready: req_ready=%b, required 10", req_ready);
    else passCount++;
    tick();
    checkCount++;
    if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_data !== 64'd4 || conflict_cnt !== 16'd6)
      $display("[TB] FAIL bp_no_bubble: valid=%0b id=%0b data=%h cnt=%0d, required 1 1 %h 6",
               resp_valid, resp_id, resp_data, conflict_cnt, 64'd4);
    else passCount++;
    req_valid = 2'b00;
    tick();
    checkCount++;
    if (resp_valid !== 1'b0)
      $display("[TB] FAIL bp_drain: resp_valid=%0b, required 0", resp_valid);
    else passCount++;
  endtask

  task automatic test_reserved();
    resp_ready = 1'b1;
    setReq1(2'b11, 1'b1, 64'h0000_0000_FFFF_0000, 6'd7);
    req_valid = 2'b10;
    tick();
    checkCount++;
    if (resp_data !== 64'hFFFF_FFFF_FFFF_0000 || resp_err !== 1'b1 || resp_id !== 1'b1)
      $display("[TB] FAIL reserved_op: data=%h err=%0b id=%0b, required %h 1 1",
               resp_data, resp_err, resp_id, 64'hFFFF_FFFF_FFFF_0000);
    else passCount++;

    setReq0(2'b00, 1'b0, 64'h1234_5678_9ABC_DEF0, 6'd0);
    req_valid = 2'b01;
    tick();
    checkCount++;
    if (resp_data !== 64'h1234_5678_9ABC_DEF0 || resp_err !== 1'b0 || resp_id !== 1'b0)
      $display("[TB] FAIL sll_zero: data=%h err=%0b id=%0b, required %h 0 0",
               resp_data, resp_err, resp_id, 64'h1234_5678_9ABC_DEF0);
    else passCount++;
    req_valid = 2'b00;
    tick();
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    reset      = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 1'b0;
    setReq0(2'b00, 1'b0, 64'd0, 6'd0);
    setReq1(2'b00, 1'b0, 64'd0, 6'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    test_reset();
    test_sra_srl();
    test_word_ops();
    test_round_robin();
    test_back_to_back();
    test_reserved();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
- Shares one 64-bit shift datapath between two requesters, for example the EX-stage ALU and the branch/address-generation path, in the pipelined core.
- Accepts SLL/SRL/SRA and RV64 word variants (SLLW/SRLW/SRAW) over valid/ready handshakes.
- Arbitrates round-robin and registers a single result with the winning requester's ID.
- Sustains one operation per cycle when the consumer never stalls.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- RR_RESET, 0, requester that holds priority after reset (0 or 1).
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept; a request is accepted when req_valid[i] & req_ready[i] are high on a clock edge.
- req0_op, req1_op  in  2 each  00 SLL, 01 SRL, 10 SRA, 11 reserved.
- req0_word, req1_word  in  1 each  1 selects a 32-bit W-variant operation.
- req0_data, req1_data  in  64 each  operand.
- req0_shamt, req1_shamt  in  6 each  shift amount.
- resp_valid  out  1  result register holds a valid result.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  64  shift result.
- resp_id  out  1  requester that issued the result.
- resp_err  out  1  the operation used the reserved opcode.
- conflict_cnt  out  CNT_W  number of cycles in which both requesters were valid and the block could accept, saturating.

Behaviour:
- Reset (async, active-high; applies immediately and is released on the next clock edge):
  - resp_valid=0, resp_data=0, resp_id=0, resp_err=0, conflict_cnt=0.
  - Round-robin pointer = RR_RESET.
  - A result held in the output register is discarded and never re-issued.
- State: RESP_EMPTY / RESP_FULL, with resp_valid as the state bit.
  - can_accept = !resp_valid | resp_ready.
- Arbitration (combinational each cycle):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester named by the pointer is granted.
  - req_ready[i] = can_accept & grant[i]. At most one ready bit is high per cycle, and ready depends combinationally on req_valid.
  - The pointer updates only on an accepted request, to the non-granted requester. With both requesters continuously valid and resp_ready=1, grants alternate 0,1,0,1... when RR_RESET=0.
- Latency: a request accepted at edge N gives resp_valid=1 with its result from just after edge N until the edge at which resp_valid & resp_ready are both high.
- Throughput:
  - Back-to-back operation: when a result is popped and a new request is accepted on the same edge, the output register loads the new result and resp_valid stays 1.
  - A pop with no new acceptance clears resp_valid to 0.
- Holding: while resp_valid=1 and resp_ready=0, resp_data, resp_id and resp_err hold, and req_ready=00.
- Arithmetic (word=0):
  - shift by shamt[5:0].
  - SLL fills low bits with 0.
  - SRL fills high bits with 0.
  - SRA fills high bits with data[63].
  - shamt=0 returns data unchanged.
- Arithmetic (word=1):
  - Operate on data[31:0] with shamt[4:0]; shamt[5] is ignored.
  - SRLW fills with 0 from bit 31; SRAW fills with data[31].
  - The 32-bit result is sign-extended from its bit 31 to 64 bits. This applies to SLLW and SRLW as well.
- Reserved op 11: resp_data = data unchanged (word=1: sign-extended data[31:0]) and resp_err=1. All other ops return resp_err=0.
- conflict_cnt: increments on any cycle with req_valid=11 and can_accept=1, and holds at all-ones once it saturates.

Test Plan:
- Reset applied mid-stall, with resp_valid=1 and resp_ready=0 → all outputs return to 0 at once; after release with no requests, resp_valid stays 0 and the pointer equals RR_RESET.
- Requester 0 only: SRA, data=0x8000_0000_0000_0000, shamt=63 → one cycle later resp_data=0xFFFF_FFFF_FFFF_FFFF, resp_id=0, resp_err=0. Same input with SRL → 0x0000_0000_0000_0001.
- Word ops from requester 1: data=0x0000_0000_8000_0000.
  - SRLW shamt=0x24 (shamt[5] ignored, shifts by 4) → 0x0000_0000_0800_0000.
  - SRAW shamt=4 → 0xFFFF_FFFF_F800_0000.
  - SLLW data=0x1, shamt=31 → 0xFFFF_FFFF_8000_0000.
- Both requesters held valid for 4 cycles with resp_ready=1 and RR_RESET=0 → resp_id sequence 0,1,0,1 on consecutive cycles; conflict_cnt=4.
- Backpressure: resp_ready=0 for 3 cycles while both requesters are valid → req_ready=00, resp_data and resp_id stable, conflict_cnt unchanged. When resp_ready rises, the pop and the next accept happen on the same edge with no bubble.
- Reserved op 11, word=1, data=0x0000_0000_FFFF_0000 → resp_data=0xFFFF_FFFF_FFFF_0000, resp_err=1. The next valid SLL shamt=0 → resp_err=0 and data unchanged.
